// File: rtl/scv_pkg.sv
// -----------------------------------------------------------------------------
// scv_pkg
// Shared types and constants for the SCV ROM initialisation loader.
//   rominit_region_t : target region of a download (BOOT, CHR, CART)
//   rominit_state_t  : loader FSM states
//   *_BYTES          : region sizes in bytes
//   HDR_BYTES        : length of the cart file header that can be stripped
//   region_limit()   : size of a region, in the width of the address counter
// -----------------------------------------------------------------------------
package scv_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        CHR  = 2'd1,
        CART = 2'd2
    } rominit_region_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } rominit_state_t;

    // The address counter must be able to hold the cart size itself (2^17),
    // because it doubles as the written-byte count.
    localparam int unsigned CNT_W = 18;

    localparam logic [CNT_W-1:0] BOOT_BYTES = 18'd4096;
    localparam logic [CNT_W-1:0] CHR_BYTES  = 18'd1024;
    localparam logic [CNT_W-1:0] CART_BYTES = 18'd131072;

    localparam logic [9:0] HDR_BYTES = 10'd512;

    function automatic logic [CNT_W-1:0] region_limit(input rominit_region_t r);
        logic [CNT_W-1:0] lim;
        lim = BOOT_BYTES;
        case (r)
            BOOT:    lim = BOOT_BYTES;
            CHR:     lim = CHR_BYTES;
            CART:    lim = CART_BYTES;
            default: lim = '0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/scv_rominit_if.sv
// -----------------------------------------------------------------------------
// scv_rominit_if
// Download stream and ROMINIT write bus of the SCV ROM loader.
//   DL_START/DL_INDEX/DL_HDR : download start pulse, region select, header flag
//   DL_DATA/DL_VALID/DL_READY: byte stream with valid/ready handshake
//   DL_END                   : end-of-file pulse
//   ROMINIT_SEL_*            : one-hot region select during a download
//   ROMINIT_ADDR/DATA/VALID  : registered byte write strobe
// Modports: master = download source / ROMINIT sink, slave = loader.
// -----------------------------------------------------------------------------
interface scv_rominit_if;

    logic        DL_START;
    logic [1:0]  DL_INDEX;
    logic        DL_HDR;
    logic [7:0]  DL_DATA;
    logic        DL_VALID;
    logic        DL_READY;
    logic        DL_END;

    logic        ROMINIT_SEL_BOOT;
    logic        ROMINIT_SEL_CHR;
    logic        ROMINIT_SEL_CART;
    logic [24:0] ROMINIT_ADDR;
    logic [7:0]  ROMINIT_DATA;
    logic        ROMINIT_VALID;

    modport master (
        output DL_START, DL_INDEX, DL_HDR, DL_DATA, DL_VALID, DL_END,
        input  DL_READY,
        input  ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
        input  ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID
    );

    modport slave (
        input  DL_START, DL_INDEX, DL_HDR, DL_DATA, DL_VALID, DL_END,
        output DL_READY,
        output ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
        output ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID
    );

endinterface

// File: rtl/scv_rominit.sv
// -----------------------------------------------------------------------------
// scv_rominit
// Streams a downloaded file into one of the SCV ROM regions (boot, chr, cart)
// as single-byte ROMINIT writes with an optional idle gap after each write.
//   CLK       : system clock (video XTAL * 2), shared with the scv core
//   RESB      : asynchronous active-low reset
//   bus       : scv_rominit_if.slave (download stream in, ROMINIT writes out)
//   BUSY      : download in progress
//   CART_SIZE : bytes written by the last completed cart download
//   ERR       : sticky overflow / invalid-index flag, cleared by DL_START
// Parameter WR_GAP (0-15): idle cycles with DL_READY low after each write.
// Build option SCV_ROMINIT_HDR_STRIP_EN: drop the first 512 bytes of a cart
// download that is flagged with DL_HDR; otherwise DL_HDR is ignored.
// -----------------------------------------------------------------------------
module scv_rominit
    import scv_pkg::*;
#(
    parameter int unsigned WR_GAP = 1
)
(
    input  logic              CLK,
    input  logic              RESB,
    scv_rominit_if.slave      bus,
    output logic              BUSY,
    output logic [CNT_W-1:0]  CART_SIZE,
    output logic              ERR
);

    localparam logic [3:0] GAP_LOAD = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

    rominit_state_t   state,     state_n;
    rominit_region_t  region,    region_n;
    logic [CNT_W-1:0] addr,      addr_n;
    logic [3:0]       gap_cnt,   gap_n;
    logic             wr_valid,  wr_valid_n;
    logic [CNT_W-1:0] wr_addr,   wr_addr_n;
    logic [7:0]       wr_data,   wr_data_n;
    logic             busy,      busy_n;
    logic             err,       err_n;
    logic [CNT_W-1:0] cart_size, cart_size_n;

    logic             accept;
    logic             hdr_skip;
    logic [CNT_W-1:0] limit;

    assign accept = (state == LOAD) && bus.DL_VALID;
    assign limit  = region_limit(region);

`ifdef SCV_ROMINIT_HDR_STRIP_EN
    // Remaining header bytes to swallow; loaded only for a cart start with DL_HDR.
    logic [9:0] hdr_left;

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            hdr_left <= '0;
        end else if (bus.DL_START) begin
            hdr_left <= (bus.DL_INDEX == CART && bus.DL_HDR) ? HDR_BYTES : '0;
        end else if (accept && hdr_left != '0) begin
            hdr_left <= hdr_left - 10'd1;
        end
    end

    assign hdr_skip = (hdr_left != '0);
`else
    logic unused_hdr;
    assign unused_hdr = bus.DL_HDR;
    assign hdr_skip   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state     <= IDLE;
            region    <= BOOT;
            addr      <= '0;
            gap_cnt   <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cart_size <= '0;
        end else begin
            state     <= state_n;
            region    <= region_n;
            addr      <= addr_n;
            gap_cnt   <= gap_n;
            wr_valid  <= wr_valid_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            busy      <= busy_n;
            err       <= err_n;
            cart_size <= cart_size_n;
        end
    end

    always_comb begin
        state_n     = state;
        region_n    = region;
        addr_n      = addr;
        gap_n       = gap_cnt;
        wr_valid_n  = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        busy_n      = busy;
        err_n       = err;
        cart_size_n = cart_size;

        if (bus.DL_START) begin
            // Start has priority over everything, including DL_END and a byte
            // accepted in this same cycle (that byte is dropped).
            if (bus.DL_INDEX == 2'd3) begin
                err_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end else begin
                err_n    = 1'b0;
                busy_n   = 1'b1;
                region_n = rominit_region_t'(bus.DL_INDEX);
                addr_n   = '0;
                state_n  = LOAD;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept && !hdr_skip) begin
                        if (addr >= limit) begin
                            // Overflow bytes are consumed silently, without a gap.
                            err_n = 1'b1;
                        end else begin
                            wr_valid_n = 1'b1;
                            wr_addr_n  = addr;
                            wr_data_n  = bus.DL_DATA;
                            addr_n     = addr + 18'd1;
                            if (WR_GAP != 0) begin
                                state_n = GAP;
                                gap_n   = GAP_LOAD;
                            end
                        end
                    end
                    if (bus.DL_END) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        if (region == CART) cart_size_n = addr_n;
                    end
                end
                GAP: begin
                    if (bus.DL_END) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        if (region == CART) cart_size_n = addr;
                    end else if (gap_cnt == 4'd0) begin
                        state_n = LOAD;
                    end else begin
                        gap_n = gap_cnt - 4'd1;
                    end
                end
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.DL_READY         = (state == LOAD);
    assign bus.ROMINIT_SEL_BOOT = busy && (region == BOOT);
    assign bus.ROMINIT_SEL_CHR  = busy && (region == CHR);
    assign bus.ROMINIT_SEL_CART = busy && (region == CART);
    assign bus.ROMINIT_ADDR     = {7'd0, wr_addr};
    assign bus.ROMINIT_DATA     = wr_data;
    assign bus.ROMINIT_VALID    = wr_valid;

    assign BUSY      = busy;
    assign CART_SIZE = cart_size;
    assign ERR       = err;

endmodule

// File: tb/tb_scv_rominit.sv
// -----------------------------------------------------------------------------
// tb_scv_rominit
// Bench for scv_rominit. Two instances: u_dut_a (WR_GAP=1) and u_dut_b
// (WR_GAP=0); dsel routes the stream strobes to one of them. Expected writes
// are queued when a byte is accepted and popped by a strobe monitor.
// Honours SCV_ROMINIT_HDR_STRIP_EN for the header-strip expectations.
// -----------------------------------------------------------------------------
module tb_scv_rominit;

`ifdef SCV_ROMINIT_HDR_STRIP_EN
    localparam int HDR_SKIP = 512;
`else
    localparam int HDR_SKIP = 0;
`endif

    typedef struct {
        bit          dut;
        logic [2:0]  sel;
        logic [24:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk;
    logic resb;

    bit         dsel;
    logic       drv_start, drv_hdr, drv_valid, drv_end;
    logic [1:0] drv_index;
    logic [7:0] drv_data;

    logic        busy_a, busy_b, err_a, err_b;
    logic [17:0] cart_size_a, cart_size_b;
    logic        cur_ready;

    scv_rominit_if if_a();
    scv_rominit_if if_b();

    assign if_a.DL_START = drv_start & !dsel;
    assign if_a.DL_VALID = drv_valid & !dsel;
    assign if_a.DL_END   = drv_end & !dsel;
    assign if_a.DL_INDEX = drv_index;
    assign if_a.DL_HDR   = drv_hdr;
    assign if_a.DL_DATA  = drv_data;

    assign if_b.DL_START = drv_start & dsel;
    assign if_b.DL_VALID = drv_valid & dsel;
    assign if_b.DL_END   = drv_end & dsel;
    assign if_b.DL_INDEX = drv_index;
    assign if_b.DL_HDR   = drv_hdr;
    assign if_b.DL_DATA  = drv_data;

    assign cur_ready = dsel ? if_b.DL_READY : if_a.DL_READY;

    scv_rominit #(.WR_GAP(1)) u_dut_a (
        .CLK(clk), .RESB(resb), .bus(if_a),
        .BUSY(busy_a), .CART_SIZE(cart_size_a), .ERR(err_a)
    );

    scv_rominit #(.WR_GAP(0)) u_dut_b (
        .CLK(clk), .RESB(resb), .bus(if_b),
        .BUSY(busy_b), .CART_SIZE(cart_size_b), .ERR(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    // Reference model of the current download
    bit         m_dut;
    logic [2:0] m_sel;
    int         m_addr, m_limit, m_hdr_left;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_strobe(input bit d, input logic [2:0] s,
                                input logic [24:0] a, input logic [7:0] v);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_strobe: got dut=%0d sel=%b addr=0x%0h data=0x%0h expected no strobe",
                     d, s, a, v);
        end else begin
            e = exp_q.pop_front();
            chk("strobe", {27'd0, d, s, a, v}, {27'd0, e.dut, e.sel, e.addr, e.data});
        end
    endtask

    always @(negedge clk) begin
        if (if_a.ROMINIT_VALID)
            check_strobe(1'b0, {if_a.ROMINIT_SEL_CART, if_a.ROMINIT_SEL_CHR, if_a.ROMINIT_SEL_BOOT},
                         if_a.ROMINIT_ADDR, if_a.ROMINIT_DATA);
        if (if_b.ROMINIT_VALID)
            check_strobe(1'b1, {if_b.ROMINIT_SEL_CART, if_b.ROMINIT_SEL_CHR, if_b.ROMINIT_SEL_BOOT},
                         if_b.ROMINIT_ADDR, if_b.ROMINIT_DATA);
    end

    task automatic model_start(input int idx, input bit hdr);
        m_dut  = dsel;
        m_addr = 0;
        case (idx)
            0:       begin m_sel = 3'b001; m_limit = 4096;   end
            1:       begin m_sel = 3'b010; m_limit = 1024;   end
            default: begin m_sel = 3'b100; m_limit = 131072; end
        endcase
        m_hdr_left = (idx == 2 && hdr) ? HDR_SKIP : 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        exp_t e;
        if (m_hdr_left > 0) begin
            m_hdr_left--;
        end else if (m_addr < m_limit) begin
            e.dut  = m_dut;
            e.sel  = m_sel;
            e.addr = 25'(m_addr);
            e.data = b;
            exp_q.push_back(e);
            m_addr++;
        end
    endtask

    task automatic start_dl(input int idx, input bit hdr);
        drv_index = 2'(idx);
        drv_hdr   = hdr;
        drv_start = 1'b1;
        if (idx != 3) model_start(idx, hdr);
        @(posedge clk); #1;
        drv_start = 1'b0;
    endtask

    // Leaves DL_VALID high so consecutive calls form a continuous stream.
    task automatic send_byte(input logic [7:0] b, output int stalls);
        logic rdy;
        drv_valid = 1'b1;
        drv_data  = b;
        stalls    = 0;
        rdy       = 1'b0;
        forever begin
            @(negedge clk);
            rdy = cur_ready;
            @(posedge clk); #1;
            if (rdy) break;
            stalls++;
            if (stalls > 40) begin
                n_checks++;
                $display("FAIL ready_timeout: got no DL_READY in 40 cycles expected acceptance");
                break;
            end
        end
        if (rdy) model_accept(b);
    endtask

    task automatic stream(input int n, input int mul, input int add, output int stalls);
        int s;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(8'(i * mul + add), s);
            stalls += s;
        end
    endtask

    task automatic end_dl();
        drv_valid = 1'b0;
        drv_end   = 1'b1;
        @(posedge clk); #1;
        drv_end   = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        resb = 1'b0; dsel = 1'b0;
        drv_start = 1'b0; drv_hdr = 1'b0; drv_valid = 1'b0; drv_end = 1'b0;
        drv_index = 2'd0; drv_data = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {if_a.DL_READY, if_a.ROMINIT_VALID, if_a.ROMINIT_SEL_BOOT, if_a.ROMINIT_SEL_CHR,
                        if_a.ROMINIT_SEL_CART, busy_a, err_a, cart_size_a, if_a.ROMINIT_ADDR}, 64'd0);
        chk("reset_b", {if_b.DL_READY, if_b.ROMINIT_VALID, busy_b, err_b, cart_size_b}, 64'd0);
        resb = 1'b1;
        @(posedge clk); #1;

        // Boot load, WR_GAP=1: ready every other cycle
        start_dl(0, 1'b0);
        chk("boot_busy_start", busy_a, 1);
        chk("boot_sel", {if_a.ROMINIT_SEL_CART, if_a.ROMINIT_SEL_CHR, if_a.ROMINIT_SEL_BOOT}, 3'b001);
        stream(4096, 1, 0, st);
        chk("boot_stalls", st, 4095);
        chk("boot_busy_before_end", busy_a, 1);
        end_dl();
        chk("boot_busy_after_end", busy_a, 0);
        chk("boot_sel_after_end", if_a.ROMINIT_SEL_BOOT, 0);
        chk("boot_err", err_a, 0);
        chk("boot_writes", exp_q.size(), 0);

        // Chr overflow: 1030 bytes, 1024 writes, no extra stalls
        start_dl(1, 1'b0);
        stream(1030, 3, 1, st);
        chk("chr_stalls", st, 1024);
        chk("chr_err", err_a, 1);
        end_dl();
        chk("chr_err_sticky", err_a, 1);
        chk("chr_writes", exp_q.size(), 0);

        // Restart mid boot load with a byte offered in the restart cycle
        start_dl(0, 1'b0);
        chk("restart_err_cleared", err_a, 0);
        stream(10, 5, 2, st);
        drv_valid = 1'b0;
        @(posedge clk); #1;
        drv_data  = 8'hEE;
        drv_valid = 1'b1;
        start_dl(1, 1'b0);
        drv_valid = 1'b0;
        chk("restart_sel", {if_a.ROMINIT_SEL_CART, if_a.ROMINIT_SEL_CHR, if_a.ROMINIT_SEL_BOOT}, 3'b010);
        chk("restart_busy", busy_a, 1);
        stream(4, 1, 8'h40, st);
        end_dl();
        chk("restart_writes", exp_q.size(), 0);

        // Cart load on WR_GAP=0 with DL_VALID held high
        dsel = 1'b1;
        @(posedge clk); #1;
        start_dl(2, 1'b0);
        stream(8192, 7, 3, st);
        chk("cart_stalls", st, 0);
        end_dl();
        chk("cart_size_b", cart_size_b, 8192);
        chk("cart_busy_b", busy_b, 0);
        chk("cart_writes", exp_q.size(), 0);

        // Cart with header flag on WR_GAP=1
        dsel = 1'b0;
        @(posedge clk); #1;
        start_dl(2, 1'b1);
        stream(528, 7, 3, st);
        end_dl();
        chk("hdr_cart_size", cart_size_a, 528 - HDR_SKIP);
        chk("hdr_writes", exp_q.size(), 0);

        // Reset mid cart load with a write pending
        start_dl(2, 1'b0);
        stream(20, 1, 8'h80, st);
        chk("pre_reset_valid", if_a.ROMINIT_VALID, 1);
        resb = 1'b0;
        #1;
        chk("reset_mid_a", {if_a.DL_READY, if_a.ROMINIT_VALID, if_a.ROMINIT_SEL_BOOT, if_a.ROMINIT_SEL_CHR,
                            if_a.ROMINIT_SEL_CART, busy_a, err_a, cart_size_a, if_a.ROMINIT_ADDR,
                            if_a.ROMINIT_DATA}, 64'd0);
        chk("reset_mid_b", cart_size_b, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        drv_valid = 1'b0;
        resb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("after_reset_idle", {if_a.DL_READY, busy_a}, 0);

        // Invalid index
        start_dl(3, 1'b0);
        chk("invalid_err", err_a, 1);
        chk("invalid_busy", busy_a, 0);
        chk("invalid_ready", if_a.DL_READY, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
